uart_stream_buffer: RTL

- Byte-stream buffer between the rv32 core's UART ports and the USB-CDC UART.
- TX path: core write port -> FIFO -> USB UART input.
- RX path: USB UART output -> FIFO -> core read port.
- Decouples the core's one-byte-per-cycle handshakes from USB back-pressure so neither side stalls on a momentary not-ready. Single clock domain; both sides run on CLK.

---
 rtl/uart_buf_pkg.sv | 10 +
 rtl/byte_fifo.sv | 64 ++++++
 rtl/uart_stream_buffer.sv | 58 +++++
 3 files changed

// File: rtl/uart_buf_pkg.sv
// Shared types and constants for the UART stream buffer.
//   byte_t        : 8-bit payload type carried by every FIFO.
//   DEFAULT_DEPTH : default number of entries per FIFO.
package uart_buf_pkg;

  typedef logic [7:0] byte_t;

  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with valid/ready handshakes on both sides.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   in_valid/in_data    : producer offers a byte
//   in_ready            : FIFO can accept (not full, not in reset)
//   out_valid/out_data  : FIFO head byte is available
//   out_ready           : consumer takes the head byte
//   level               : occupancy 0..DEPTH
module byte_fifo
  import uart_buf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  input  byte_t       in_data,
  output logic        in_ready,
  output logic        out_valid,
  output byte_t       out_data,
  input  logic        out_ready,
  output logic [AW:0] level
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  byte_t       mem [DEPTH];
  logic [AW:0] wp_reg;
  logic [AW:0] rp_reg;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  // Pointers carry one extra bit so that equal addresses can be told apart
  // as "empty" (same lap) or "full" (writer one lap ahead).
  assign empty = (wp_reg == rp_reg);
  assign full  = (wp_reg[AW-1:0] == rp_reg[AW-1:0]) && (wp_reg[AW] != rp_reg[AW]);

  // Ready is forced low while reset is held so nothing is accepted then.
  assign in_ready  = !full && RST_N;
  assign out_valid = !empty;
  assign out_data  = mem[rp_reg[AW-1:0]];
  assign level     = wp_reg - rp_reg;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp_reg <= '0;
      rp_reg <= '0;
    end else begin
      if (push) wp_reg <= wp_reg + PTR_ONE;
      if (pop)  rp_reg <= rp_reg + PTR_ONE;
    end
  end

  // Storage needs no reset: contents are only observable between rp and wp.
  always_ff @(posedge CLK) begin
    if (push) mem[wp_reg[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/uart_stream_buffer.sv
// Byte-stream buffer between the core UART ports and the USB-CDC UART.
// TX: core write port -> FIFO -> USB UART input.
// RX: USB UART output -> FIFO -> core read port.
//   CLK, RST_N                           : clock, asynchronous active-low reset
//   core_wr_valid/core_wr_data/_ready    : core TX byte handshake
//   core_rd_valid/core_rd_data/_ready    : core RX byte handshake
//   usb_in_valid/usb_in_data/_ready      : TX bytes toward the USB UART
//   usb_out_valid/usb_out_data/_ready    : RX bytes from the USB UART
//   tx_level, rx_level                   : FIFO occupancies 0..DEPTH
module uart_stream_buffer
  import uart_buf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        core_wr_valid,
  input  byte_t       core_wr_data,
  output logic        core_wr_ready,
  input  logic        core_rd_ready,
  output logic        core_rd_valid,
  output byte_t       core_rd_data,
  output logic        usb_in_valid,
  output byte_t       usb_in_data,
  input  logic        usb_in_ready,
  input  logic        usb_out_valid,
  input  byte_t       usb_out_data,
  output logic        usb_out_ready,
  output logic [AW:0] tx_level,
  output logic [AW:0] rx_level
);

  byte_fifo #(.DEPTH(DEPTH)) tx_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (core_wr_valid),
    .in_data   (core_wr_data),
    .in_ready  (core_wr_ready),
    .out_valid (usb_in_valid),
    .out_data  (usb_in_data),
    .out_ready (usb_in_ready),
    .level     (tx_level)
  );

  byte_fifo #(.DEPTH(DEPTH)) rx_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (usb_out_valid),
    .in_data   (usb_out_data),
    .in_ready  (usb_out_ready),
    .out_valid (core_rd_valid),
    .out_data  (core_rd_data),
    .out_ready (core_rd_ready),
    .level     (rx_level)
  );

endmodule
